// File: rtl/mac_array_pkg.sv
// Shared definitions for the MAC array controller.
//   state_t   : controller FSM states
//   DEF_*     : default parameter values used by mac_array_ctrl and lane_fifo
//   acc_w_ok  : elaboration-time check that the accumulator can hold one product
package mac_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;

  // A single unsigned DATA_W x DATA_W product needs 2*DATA_W bits.
  function automatic bit acc_w_ok(input int acc_w, input int data_w);
    return acc_w >= 2 * data_w;
  endfunction

endpackage

// File: rtl/mac_array_ctrl_lane_fifo.sv
// lane_fifo: one matrix row worth of elements.
// A push loads a whole memory row (COLS elements) at once; each pop returns
// one element, element 0 first. Because a push writes the full depth, a push
// is only legal into an empty FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : load push_data (COLS*DATA_W bits) into the FIFO
//   pop        : advance to the next element
//   pop_data   : element at the head of the FIFO
//   full/empty : occupancy flags
module lane_fifo
  import mac_array_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [COLS*DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      pop_data,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CW = $clog2(COLS + 1);
  localparam logic [CW-1:0] DEPTH = CW'(COLS);
  localparam logic [PW-1:0] LAST  = PW'(COLS - 1);

  logic [DATA_W-1:0] mem [COLS];
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < COLS; k++) mem[k] <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      for (int k = 0; k < COLS; k++) mem[k] <= push_data[k*DATA_W +: DATA_W];
      rd_ptr <= '0;
      count  <= DEPTH;
    end else if (pop) begin
      rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      count  <= count - CW'(1);
    end
  end

  a_push_needs_room: assert property (@(posedge clk) disable iff (!rst_n) push |-> empty);
  a_pop_needs_data:  assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: matrix-vector multiply controller.
// Fetches ROWS matrix rows plus one vector row from memory (one read in
// flight at a time), parks each row in its own lane_fifo, then streams all
// FIFOs in lock-step for COLS cycles while ROWS lanes multiply-accumulate.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, acc_mode   : run request; acc_mode=1 keeps prior accumulators/ovf
//   base_addr         : word address of matrix row 0 (vector row follows row ROWS-1)
//   mem_*             : read-only memory master (address/read/waitrequest,
//                       readdata qualified by readdatavalid)
//   busy              : high while fetching or accumulating
//   done              : one-cycle pulse when result is updated
//   ovf               : sticky per-lane accumulator carry-out
//   result            : lane i at [i*ACC_W +: ACC_W], held until the next done
module mac_array_ctrl
  import mac_array_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   acc_mode,
  input  logic [31:0]            base_addr,
  output logic [31:0]            mem_address,
  output logic                   mem_read,
  input  logic [COLS*DATA_W-1:0] mem_readdata,
  input  logic                   mem_readdatavalid,
  input  logic                   mem_waitrequest,
  output logic                   busy,
  output logic                   done,
  output logic [ROWS-1:0]        ovf,
  output logic [ROWS*ACC_W-1:0]  result
);

  localparam int NF = ROWS + 1;
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = 2 * DATA_W;
  localparam int SW = ACC_W + 1;
  localparam logic [RW-1:0] B_ROW    = RW'(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  if (!acc_w_ok(ACC_W, DATA_W)) begin : g_acc_w_check
    $error("mac_array_ctrl: ACC_W must be at least 2*DATA_W");
  end

  state_t            state;
  logic [RW-1:0]     row_idx;
  logic [CW-1:0]     col_cnt;
  logic [ACC_W-1:0]  acc [ROWS];

  logic [NF-1:0]     push;
  logic [NF-1:0]     pop;
  logic [NF-1:0]     fifo_full;
  logic [NF-1:0]     fifo_empty;
  logic [DATA_W-1:0] pop_data [NF];
  logic [PW-1:0]     prod [ROWS];
  logic [SW-1:0]     sum [ROWS];
  logic              rsp_accept;

  // mem_read is low in FILL only while the accepted read awaits its data,
  // so this also rejects a stray readdatavalid in the first FILL cycle.
  assign rsp_accept = (state == FILL) && !mem_read && mem_readdatavalid;

  always_comb begin
    push = '0;
    if (rsp_accept) push[row_idx] = 1'b1;
  end

  assign pop = {NF{state == EXEC}};

  for (genvar r = 0; r < NF; r++) begin : g_fifo
    lane_fifo #(
      .COLS   (COLS),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[r]),
      .push_data (mem_readdata),
      .pop       (pop[r]),
      .pop_data  (pop_data[r]),
      .full      (fifo_full[r]),
      .empty     (fifo_empty[r])
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push[r] |-> !fifo_full[r]);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop[r] |-> !fifo_empty[r]);
  end

  // Lane datapath: FIFO ROWS carries the shared vector element.
  // The extra sum bit is the carry-out that feeds ovf.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      prod[i] = PW'(pop_data[i]) * PW'(pop_data[ROWS]);
      sum[i]  = {1'b0, acc[i]} + SW'(prod[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_idx     <= '0;
      col_cnt     <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= '0;
      result      <= '0;
      for (int i = 0; i < ROWS; i++) acc[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FILL;
            busy        <= 1'b1;
            row_idx     <= '0;
            mem_address <= base_addr;
            mem_read    <= 1'b1;
            if (!acc_mode) begin
              ovf <= '0;
              for (int i = 0; i < ROWS; i++) acc[i] <= '0;
            end
          end
        end

        FILL: begin
          if (mem_read && !mem_waitrequest) mem_read <= 1'b0;
          if (rsp_accept) begin
            if (row_idx == B_ROW) begin
              state   <= EXEC;
              col_cnt <= '0;
            end else begin
              row_idx     <= row_idx + RW'(1);
              mem_address <= mem_address + 32'd1;
              mem_read    <= 1'b1;
            end
          end
        end

        EXEC: begin
          for (int i = 0; i < ROWS; i++) begin
            acc[i] <= sum[i][ACC_W-1:0];
            if (sum[i][ACC_W]) ovf[i] <= 1'b1;
          end
          if (col_cnt == LAST_COL) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            for (int i = 0; i < ROWS; i++) result[i*ACC_W +: ACC_W] <= sum[i][ACC_W-1:0];
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl.
// u_dut0: default parameters, memory model with random wait/latency.
// u_dut1: ACC_W=16, all elements 255 (overflow case).
// u_dut2: ROWS=4, COLS=16, DATA_W=4, all elements 15.
module tb_mac_array_ctrl;

  logic clk;
  logic rst_n;

  // DUT0 (defaults)
  logic         start0, mode0;
  logic [31:0]  base0, addr0;
  logic         rd0, rvld0, wreq0, busy0, done0;
  logic [63:0]  rdata0;
  logic [7:0]   ovf0;
  logic [191:0] res0;

  // DUT1 (ACC_W=16)
  logic         start1, mode1;
  logic [31:0]  addr1;
  logic         rd1, rvld1, wreq1, busy1, done1;
  logic [63:0]  rdata1;
  logic [7:0]   ovf1;
  logic [127:0] res1;

  // DUT2 (ROWS=4, COLS=16, DATA_W=4)
  logic         start2, mode2;
  logic [31:0]  addr2;
  logic         rd2, rvld2, wreq2, busy2, done2;
  logic [63:0]  rdata2;
  logic [3:0]   ovf2;
  logic [95:0]  res2;

  mac_array_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .acc_mode(mode0), .base_addr(base0),
    .mem_address(addr0), .mem_read(rd0), .mem_readdata(rdata0),
    .mem_readdatavalid(rvld0), .mem_waitrequest(wreq0),
    .busy(busy0), .done(done0), .ovf(ovf0), .result(res0)
  );

  mac_array_ctrl #(.ACC_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .acc_mode(mode1), .base_addr(32'h10),
    .mem_address(addr1), .mem_read(rd1), .mem_readdata(rdata1),
    .mem_readdatavalid(rvld1), .mem_waitrequest(wreq1),
    .busy(busy1), .done(done1), .ovf(ovf1), .result(res1)
  );

  mac_array_ctrl #(.ROWS(4), .COLS(16), .DATA_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .acc_mode(mode2), .base_addr(32'h20),
    .mem_address(addr2), .mem_read(rd2), .mem_readdata(rdata2),
    .mem_readdatavalid(rvld2), .mem_waitrequest(wreq2),
    .busy(busy2), .done(done2), .ovf(ovf2), .result(res2)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  // memory model state for DUT0
  int          pat, wmax, lmin, lmax;
  logic [31:0] base_cur, exp_addr;
  bit          addr_err, ovl_err;
  int          n_acc, n_vld, vld0_cyc, vld2_cyc;

  typedef struct {
    int          pat;
    logic        mode;
    int          wmax;
    int          lmax;
    logic [31:0] base;
    int          exp_base;
    int          exp_step;
    logic        poke;
  } vec_t;

  vec_t vecs [7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] row_data0(input int p, input logic [31:0] r);
    logic [63:0] d;
    logic [7:0]  e;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      case (p)
        0:       e = (r < 8) ? 8'(r + 1) : 8'(k + 1);
        1:       e = (r < 8) ? 8'(k) : 8'd2;
        2:       e = (r < 8) ? ((r == k) ? 8'd3 : 8'd0) : 8'(k + 1);
        default: e = (r < 8) ? 8'd200 : 8'd250;
      endcase
      d[k*8 +: 8] = e;
    end
    return d;
  endfunction

  // DUT0 memory: random waitrequest, random readdatavalid latency, and
  // protocol monitors (address order/stability, one read outstanding).
  initial begin : resp0
    logic        rd_q, wr_q, wr;
    logic [31:0] addr_q, pend_addr;
    int          lat, wcnt;
    rd_q = 1'b0; wr_q = 1'b0; addr_q = '0; pend_addr = '0; lat = -1; wcnt = -1;
    rvld0 = 1'b0; wreq0 = 1'b0; rdata0 = '0;
    forever begin
      @(posedge clk);
      #1;
      rvld0  = 1'b0;
      rdata0 = '0;
      if (rd_q && !wr_q) begin
        if (lat >= 0) ovl_err = 1'b1;
        if (addr_q !== exp_addr) addr_err = 1'b1;
        exp_addr  = exp_addr + 32'd1;
        n_acc++;
        pend_addr = addr_q;
        lat       = int'($urandom_range(lmax, lmin)) - 1;
        wcnt      = -1;
      end else if (rd_q && wr_q && rd0 && (addr0 !== addr_q)) begin
        addr_err = 1'b1;
      end
      if (rd_q && wr_q && !rd0 && rst_n) addr_err = 1'b1;
      if (lat >= 0 && rd0) ovl_err = 1'b1;
      if (lat == 0) begin
        rvld0    = 1'b1;
        rdata0   = row_data0(pat, pend_addr - base_cur);
        vld0_cyc = cyc;
        n_vld++;
        lat      = -1;
      end else if (lat > 0) begin
        lat--;
      end
      if (rd0) begin
        if (wcnt < 0) wcnt = int'($urandom_range(wmax, 0));
        wr = (wcnt > 0);
        if (wcnt > 0) wcnt--;
      end else begin
        wr   = 1'b0;
        wcnt = -1;
      end
      wreq0  = wr;
      rd_q   = rd0;
      wr_q   = wr;
      addr_q = addr0;
    end
  end

  // DUT1/DUT2 memory: no wait states, data one cycle after the request.
  initial begin : resp12
    logic rd1_q, rd2_q;
    rd1_q = 1'b0; rd2_q = 1'b0;
    rvld1 = 1'b0; wreq1 = 1'b0; rdata1 = '1;
    rvld2 = 1'b0; wreq2 = 1'b0; rdata2 = '1;
    forever begin
      @(posedge clk);
      #1;
      rvld1 = rd1_q;
      rvld2 = rd2_q;
      if (rd2_q) vld2_cyc = cyc;
      rd1_q = rd1;
      rd2_q = rd2;
    end
  end

  task automatic start_run0(input int p, input logic m, input int w, input int lo, input int hi,
                            input logic [31:0] b);
    pat = p; base_cur = b; exp_addr = b; wmax = w; lmin = lo; lmax = hi;
    addr_err = 1'b0; ovl_err = 1'b0; n_acc = 0; n_vld = 0;
    @(posedge clk); #2;
    start0 = 1'b1; mode0 = m; base0 = b;
    @(posedge clk); #2;
    start0 = 1'b0; base0 = 32'hDEAD_0000;
  endtask

  task automatic finish_run0(input int eb, input int es, input logic poke, input string tag);
    bit seen;
    int done_cyc;
    seen = 1'b0; done_cyc = 0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(posedge clk); #2;
      if (poke && t == 4) begin start0 = 1'b1; mode0 = 1'b0; end
      if (poke && t == 5) start0 = 1'b0;
      if (done0) begin seen = 1'b1; done_cyc = cyc; end
    end
    chk({tag, " done_seen"}, 256'(seen), 256'(1));
    chk({tag, " exec_cycles"}, 256'(done_cyc - vld0_cyc), 256'(9));
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s lane%0d", tag, i), 256'(res0[i*24 +: 24]), 256'(24'(eb + es * i)));
    chk({tag, " ovf"}, 256'(ovf0), 256'(0));
    chk({tag, " busy_after"}, 256'(busy0), 256'(0));
    chk({tag, " reads"}, 256'(n_acc), 256'(9));
    chk({tag, " addr_order"}, 256'(addr_err), 256'(0));
    chk({tag, " one_outstanding"}, 256'(ovl_err), 256'(0));
    @(posedge clk); #2;
    chk({tag, " done_pulse"}, 256'(done0), 256'(0));
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, " busy"}, 256'(busy0), 256'(0));
    chk({tag, " done"}, 256'(done0), 256'(0));
    chk({tag, " mem_read"}, 256'(rd0), 256'(0));
    chk({tag, " mem_address"}, 256'(addr0), 256'(0));
    chk({tag, " result"}, 256'(res0), 256'(0));
    chk({tag, " ovf"}, 256'(ovf0), 256'(0));
  endtask

  initial begin
    bit seen;
    int done_cyc;
    rst_n = 1'b0;
    start0 = 1'b0; mode0 = 1'b0; base0 = '0;
    start1 = 1'b0; mode1 = 1'b0;
    start2 = 1'b0; mode2 = 1'b0;
    pat = 0; wmax = 0; lmin = 1; lmax = 1; base_cur = '0; exp_addr = '0;
    addr_err = 1'b0; ovl_err = 1'b0; n_acc = 0; n_vld = 0; vld0_cyc = 0; vld2_cyc = 0;

    vecs[0] = '{pat:0, mode:1'b0, wmax:0, lmax:1, base:32'h0000_0100, exp_base:36,     exp_step:36, poke:1'b0};
    vecs[1] = '{pat:0, mode:1'b1, wmax:5, lmax:4, base:32'h0000_0100, exp_base:72,     exp_step:72, poke:1'b1};
    vecs[2] = '{pat:0, mode:1'b0, wmax:5, lmax:4, base:32'h8000_0000, exp_base:36,     exp_step:36, poke:1'b0};
    vecs[3] = '{pat:1, mode:1'b0, wmax:2, lmax:3, base:32'h0000_0040, exp_base:56,     exp_step:0,  poke:1'b0};
    vecs[4] = '{pat:2, mode:1'b0, wmax:0, lmax:2, base:32'h0000_0000, exp_base:3,      exp_step:3,  poke:1'b1};
    vecs[5] = '{pat:3, mode:1'b0, wmax:3, lmax:1, base:32'h0000_1234, exp_base:400000, exp_step:0,  poke:1'b0};
    vecs[6] = '{pat:3, mode:1'b1, wmax:1, lmax:2, base:32'h0000_1234, exp_base:800000, exp_step:0,  poke:1'b0};

    repeat (3) @(posedge clk);
    #2;
    chk_zero0("reset");
    chk("reset dut1 result", 256'(res1), 256'(0));
    chk("reset dut2 ovf", 256'(ovf2), 256'(0));
    rst_n = 1'b1;

    // Table-driven runs on the default-size array.
    for (int v = 0; v < 7; v++) begin
      start_run0(vecs[v].pat, vecs[v].mode, vecs[v].wmax, 1, vecs[v].lmax, vecs[v].base);
      finish_run0(vecs[v].exp_base, vecs[v].exp_step, vecs[v].poke, $sformatf("vec%0d", v));
    end

    // Reset in FILL with a read still outstanding; its data arrives while idle.
    start_run0(0, 1'b0, 0, 4, 4, 32'h0000_0200);
    for (int t = 0; t < 200 && n_acc < 3; t++) begin
      @(posedge clk); #2;
    end
    chk("rstfill reached", 256'(n_acc >= 3), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("rstfill async busy", 256'(busy0), 256'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk_zero0("rstfill");
    repeat (8) @(posedge clk);
    #2;
    chk("rstfill stale ignored rd", 256'(rd0), 256'(0));
    chk("rstfill stale ignored busy", 256'(busy0), 256'(0));
    start_run0(0, 1'b0, 2, 1, 3, 32'h0000_0300);
    finish_run0(36, 36, 1'b0, "after_rstfill");

    // Reset in EXEC; a following acc_mode=1 run must start from zero.
    start_run0(0, 1'b0, 0, 1, 1, 32'h0000_0400);
    for (int t = 0; t < 300 && n_vld < 9; t++) begin
      @(posedge clk); #2;
    end
    chk("rstexec reached", 256'(n_vld), 256'(9));
    repeat (3) @(posedge clk);
    #2;
    chk("rstexec in exec", 256'(busy0), 256'(1));
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk_zero0("rstexec");
    start_run0(0, 1'b1, 1, 1, 2, 32'h0000_0500);
    finish_run0(36, 36, 1'b0, "after_rstexec");

    // ACC_W=16 overflow, twice with acc_mode=0 so ovf/acc must be cleared.
    for (int rep = 0; rep < 2; rep++) begin
      @(posedge clk); #2;
      start1 = 1'b1; mode1 = 1'b0;
      @(posedge clk); #2;
      start1 = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 500 && !seen; t++) begin
        @(posedge clk); #2;
        if (done1) seen = 1'b1;
      end
      chk($sformatf("ovf16 rep%0d done_seen", rep), 256'(seen), 256'(1));
      for (int i = 0; i < 8; i++)
        chk($sformatf("ovf16 rep%0d lane%0d", rep, i), 256'(res1[i*16 +: 16]), 256'(16'd61448));
      chk($sformatf("ovf16 rep%0d ovf", rep), 256'(ovf1), 256'(8'hFF));
    end

    // ROWS=4, COLS=16, DATA_W=4 geometry.
    @(posedge clk); #2;
    start2 = 1'b1; mode2 = 1'b0;
    @(posedge clk); #2;
    start2 = 1'b0;
    seen = 1'b0; done_cyc = 0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(posedge clk); #2;
      if (done2) begin seen = 1'b1; done_cyc = cyc; end
    end
    chk("geo done_seen", 256'(seen), 256'(1));
    chk("geo exec_cycles", 256'(done_cyc - vld2_cyc), 256'(17));
    for (int i = 0; i < 4; i++)
      chk($sformatf("geo lane%0d", i), 256'(res2[i*24 +: 24]), 256'(24'd3600));
    chk("geo ovf", 256'(ovf2), 256'(0));
    chk("geo busy_after", 256'(busy2), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
